wavetable_loader: RTL and testbench
===================================

Name: wavetable_loader

Overview:
- Write-side counterpart of the sound unit's playback address counter.
- Accepts a stream of PCM samples over a valid/ready handshake and writes them to consecutive addresses of the dual-port wavetable RAM, from address 0 to LAST_ADDR.
- Raises done and play_en once the table is complete. play_en drives the playback counter's external enable, so playback never reads a partially loaded table.
- Sits between the sample source (ROM/MIF streamer or host) and the wavetable RAM write port.

Parameters:
- ADDR_SIZE, 8, wavetable address width; must equal the playback counter's COUNT_SIZE.
- DATA_WIDTH, 16, sample width in bits.
- LAST_ADDR, 2**ADDR_SIZE-1, final address written; derived, must not be overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a new table load
- abort  in  1  single-cycle pulse; cancels a load in progress
- s_valid  in  1  source sample valid
- s_data  in  DATA_WIDTH  source sample
- s_ready  out  1  loader can accept a sample
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_SIZE  RAM write address
- wr_data  out  DATA_WIDTH  RAM write data
- busy  out  1  load in progress (LOAD or FLUSH)
- done  out  1  table complete and valid
- play_en  out  1  enable to playback counter; equals done
- sample_count  out  ADDR_SIZE+1  samples accepted in the current load

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0, including wr_addr, wr_data and sample_count. Reset mid-load discards the partial table: done=0, no further wr_en.
- States:
  - IDLE: s_ready=0, done=0.
  - LOAD: s_ready=1, busy=1.
  - FLUSH: s_ready=0, busy=1; final write is in flight.
  - DONE: s_ready=0, done=1, play_en=1.
- Transitions:
  - IDLE or DONE, start=1 → LOAD. Next cycle: sample_count=0, internal address=0, done=0, play_en=0.
  - LOAD, handshake (s_valid & s_ready) at address LAST_ADDR → FLUSH.
  - FLUSH → DONE unconditionally, after 1 cycle.
  - LOAD or FLUSH, abort=1 → IDLE.
- Start in LOAD or FLUSH is ignored.
- start and abort in the same cycle: abort wins. Outside LOAD/FLUSH, abort is a no-op.
- Handshake in LOAD: s_valid & s_ready accepts s_data.
  - Next cycle: wr_en=1, wr_addr = accepted address, wr_data = s_data. Write latency is 1 cycle.
  - sample_count and the internal address increment on each handshake.
- wr_en is a single-cycle strobe per accepted sample; it is 0 in all other cycles. wr_addr/wr_data hold their last values when wr_en=0.
- Back-to-back: one sample per cycle with s_valid held high. A full table of 2**ADDR_SIZE samples takes 2**ADDR_SIZE cycles in LOAD, then 1 FLUSH cycle; done rises the cycle after the last wr_en.
- s_valid low in LOAD: stall, state and counters hold.
- The address never wraps: acceptance stops after LAST_ADDR. sample_count reaches 2**ADDR_SIZE, hence the ADDR_SIZE+1 width.
- Abort:
  - A write already registered (wr_en for the previous cycle's handshake) still appears.
  - A handshake in the abort cycle is not accepted: s_ready is forced 0 when abort=1.
  - Afterwards done=0 and sample_count holds its value until the next start.
- Reload (start in DONE): play_en drops the cycle after start, so playback halts before any overwrite.

Decomposition:
- Shared package sound_pkg: loader_state_t enum {IDLE, LOAD, FLUSH, DONE}; default DATA_WIDTH constant shared with the audio datapath.
- No sub-module. The write-address counter is inline because it needs clear-on-start and terminal detect, which the playback counter does not provide.

Test Plan (ADDR_SIZE=3, DATA_WIDTH=16 unless noted):
- Reset, then start, then 8 samples 0x1000..0x1007 back-to-back → wr_en in 8 consecutive cycles at addresses 0..7, each one cycle after its handshake; FLUSH; done=play_en=1 the cycle after address 7; sample_count=8.
- s_valid toggling 1,0,0,1,… during load → wr_addr increments only on handshakes; no wr_en during gaps; final state DONE with 8 writes total.
- Abort after 3 samples (abort concurrent with a 4th s_valid) → 4th sample not accepted; exactly 3 writes (addresses 0..2); state IDLE; done=0; sample_count=3.
- start and abort in the same cycle while in IDLE → state remains IDLE; no s_ready; no wr_en.
- From DONE, start → play_en=0 next cycle; reload of 0xA000..0xA007 → rewrites addresses 0..7; done returns.
- Assert reset at sample 5 of a load → all outputs 0 immediately (asynchronous); after release, state IDLE and start required to load.

Source files
------------

// File: rtl/sound_pkg.sv
// Types and constants shared by the sound unit's wavetable loader and audio datapath.
package sound_pkg;

   localparam int DATA_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/wavetable_loader_if.sv
// Sample-source handshake, RAM write port and status bundle of the wavetable loader.
interface wavetable_loader_if #(
   parameter int ADDR_SIZE  = 8,
   parameter int DATA_WIDTH = sound_pkg::DATA_WIDTH_DEFAULT
) ();

   // Handshake: a sample transfers in a cycle where s_valid and s_ready are both 1;
   // s_data must be stable while s_valid is high, and s_ready never depends on s_valid.
   logic                  start;
   logic                  abort;
   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;

   logic                  wr_en;
   logic [ADDR_SIZE-1:0]  wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   logic                  busy;
   logic                  done;
   logic                  play_en;
   logic [ADDR_SIZE:0]    sample_count;
   sound_pkg::loader_state_t state;

   modport master (
      output start, abort, s_valid, s_data,
      input  s_ready, wr_en, wr_addr, wr_data, busy, done, play_en, sample_count, state
   );

   modport slave (
      input  start, abort, s_valid, s_data,
      output s_ready, wr_en, wr_addr, wr_data, busy, done, play_en, sample_count, state
   );

endinterface

// File: rtl/wavetable_loader.sv
// Streams PCM samples into wavetable RAM addresses 0..LAST_ADDR, then enables playback.
module wavetable_loader
   import sound_pkg::*;
#(
   parameter int ADDR_SIZE  = 8,
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   wavetable_loader_if.slave   bus
);

   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = {ADDR_SIZE{1'b1}};
   localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
   localparam logic [ADDR_SIZE:0]   CNT_ONE   = {{ADDR_SIZE{1'b0}}, 1'b1};

   loader_state_t          state_q, state_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic [ADDR_SIZE:0]     count_q, count_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

   logic                   s_ready_c;
   logic                   busy_c;
   logic                   done_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      s_ready_c = 1'b0;
      busy_c    = 1'b0;
      done_c    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            done_c = (state_q == DONE);
            // abort beats a simultaneous start even where abort has nothing to cancel
            if (bus.start && !bus.abort) begin
               state_d = LOAD;
               addr_d  = '0;
               count_d = '0;
            end
         end

         LOAD: begin
            busy_c    = 1'b1;
            s_ready_c = !bus.abort;
            if (bus.abort) begin
               state_d = IDLE;
            end else if (bus.s_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = bus.s_data;
               addr_d    = addr_q + ADDR_ONE;
               count_d   = count_q + CNT_ONE;
               if (addr_q == LAST_ADDR) begin
                  state_d = FLUSH;
               end
            end
         end

         FLUSH: begin
            busy_c  = 1'b1;
            state_d = bus.abort ? IDLE : DONE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // play_en gates the playback counter, so it only tracks a completed table.
   assign bus.s_ready      = s_ready_c;
   assign bus.busy         = busy_c;
   assign bus.done         = done_c;
   assign bus.play_en      = done_c;
   assign bus.wr_en        = wr_en_q;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.wr_data      = wr_data_q;
   assign bus.sample_count = count_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_wavetable_loader.sv
// Directed bench for wavetable_loader with an 8-entry table.
module tb_wavetable_loader;
   import sound_pkg::*;

   localparam int AW = 3;
   localparam int DW = 16;

   typedef struct {
      logic          start;
      logic          abort;
      logic          s_valid;
      logic [DW-1:0] s_data;
      logic          exp_wr_en;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      loader_state_t exp_state;
      logic          exp_done;
      logic [AW:0]   exp_count;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [10];

   wavetable_loader_if #(.ADDR_SIZE(AW), .DATA_WIDTH(DW)) bus ();

   wavetable_loader #(.ADDR_SIZE(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives n back-to-back samples base+i and checks each write one cycle after its handshake.
   task automatic send_burst(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = base + DW'(i);
         step();
         chk("burst_wr_en",   32'(bus.wr_en),   32'd1);
         chk("burst_wr_addr", 32'(bus.wr_addr), 32'(i));
         chk("burst_wr_data", 32'(bus.wr_data), 32'(base + DW'(i)));
      end
      bus.s_valid = 1'b0;
   endtask

   initial begin
      int n_acc;
      int writes;
      logic hs;

      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;

      // Full back-to-back load of 0x1000..0x1007.
      vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, LOAD,  1'b0, 4'd0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h1000, 1'b1, 3'd0, 16'h1000, LOAD,  1'b0, 4'd1};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h1001, 1'b1, 3'd1, 16'h1001, LOAD,  1'b0, 4'd2};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h1002, 1'b1, 3'd2, 16'h1002, LOAD,  1'b0, 4'd3};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h1003, 1'b1, 3'd3, 16'h1003, LOAD,  1'b0, 4'd4};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h1004, 1'b1, 3'd4, 16'h1004, LOAD,  1'b0, 4'd5};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h1005, 1'b1, 3'd5, 16'h1005, LOAD,  1'b0, 4'd6};
      vecs[7] = '{1'b0, 1'b0, 1'b1, 16'h1006, 1'b1, 3'd6, 16'h1006, LOAD,  1'b0, 4'd7};
      vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h1007, 1'b1, 3'd7, 16'h1007, FLUSH, 1'b0, 4'd8};
      vecs[9] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd7, 16'h1007, DONE,  1'b1, 4'd8};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_state",   32'(bus.state),        32'(IDLE));
      chk("rst_wr_en",   32'(bus.wr_en),        32'd0);
      chk("rst_wr_addr", 32'(bus.wr_addr),      32'd0);
      chk("rst_wr_data", 32'(bus.wr_data),      32'd0);
      chk("rst_count",   32'(bus.sample_count), 32'd0);
      chk("rst_done",    32'(bus.done),         32'd0);
      chk("rst_play_en", 32'(bus.play_en),      32'd0);
      chk("rst_busy",    32'(bus.busy),         32'd0);
      chk("rst_s_ready", 32'(bus.s_ready),      32'd0);

      // Table-driven full load
      for (int i = 0; i < 10; i++) begin
         bus.start   = vecs[i].start;
         bus.abort   = vecs[i].abort;
         bus.s_valid = vecs[i].s_valid;
         bus.s_data  = vecs[i].s_data;
         step();
         chk("vec_wr_en",   32'(bus.wr_en),        32'(vecs[i].exp_wr_en));
         chk("vec_wr_addr", 32'(bus.wr_addr),      32'(vecs[i].exp_addr));
         chk("vec_wr_data", 32'(bus.wr_data),      32'(vecs[i].exp_data));
         chk("vec_state",   32'(bus.state),        32'(vecs[i].exp_state));
         chk("vec_done",    32'(bus.done),         32'(vecs[i].exp_done));
         chk("vec_play_en", 32'(bus.play_en),      32'(vecs[i].exp_done));
         chk("vec_count",   32'(bus.sample_count), 32'(vecs[i].exp_count));
         chk("vec_busy",    32'(bus.busy),
             32'(vecs[i].exp_state == LOAD || vecs[i].exp_state == FLUSH));
      end
      bus.start = 1'b0; bus.s_valid = 1'b0;

      // Reload from DONE: play_en drops right away, table rewritten
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("reload_play_en", 32'(bus.play_en),      32'd0);
      chk("reload_done",    32'(bus.done),         32'd0);
      chk("reload_state",   32'(bus.state),        32'(LOAD));
      chk("reload_count",   32'(bus.sample_count), 32'd0);
      send_burst(16'hA000, 8);
      chk("reload_flush", 32'(bus.state), 32'(FLUSH));
      step();
      chk("reload_done2",    32'(bus.done),         32'd1);
      chk("reload_play_en2", 32'(bus.play_en),      32'd1);
      chk("reload_count2",   32'(bus.sample_count), 32'd8);

      // s_valid pattern 1,0,0,1,0,0,...
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n_acc  = 0;
      writes = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) break;
         hs          = (k % 3 == 0) && (n_acc < 8);
         bus.s_valid = hs;
         bus.s_data  = 16'h2000 + DW'(n_acc);
         step();
         writes += int'(bus.wr_en);
         chk("tog_wr_en", 32'(bus.wr_en), 32'(hs));
         if (hs) begin
            chk("tog_wr_addr", 32'(bus.wr_addr), 32'(n_acc));
            chk("tog_wr_data", 32'(bus.wr_data), 32'(16'h2000 + DW'(n_acc)));
            n_acc++;
         end
         chk("tog_count", 32'(bus.sample_count), 32'(n_acc));
      end
      bus.s_valid = 1'b0;
      chk("tog_done",   32'(bus.done),  32'd1);
      chk("tog_state",  32'(bus.state), 32'(DONE));
      chk("tog_writes", 32'(writes),    32'd8);

      // Abort after 3 samples, concurrent with a 4th s_valid
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      send_burst(16'h3000, 3);
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h3003;
      bus.abort   = 1'b1;
      #1;
      chk("abort_s_ready", 32'(bus.s_ready), 32'd0);
      step();
      bus.abort   = 1'b0;
      bus.s_valid = 1'b0;
      chk("abort_wr_en",   32'(bus.wr_en),        32'd0);
      chk("abort_wr_addr", 32'(bus.wr_addr),      32'd2);
      chk("abort_state",   32'(bus.state),        32'(IDLE));
      chk("abort_done",    32'(bus.done),         32'd0);
      chk("abort_busy",    32'(bus.busy),         32'd0);
      chk("abort_count",   32'(bus.sample_count), 32'd3);

      // start and abort together in IDLE
      bus.start = 1'b1;
      bus.abort = 1'b1;
      #1;
      chk("sa_s_ready", 32'(bus.s_ready), 32'd0);
      step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("sa_state", 32'(bus.state),        32'(IDLE));
      chk("sa_wr_en", 32'(bus.wr_en),        32'd0);
      chk("sa_count", 32'(bus.sample_count), 32'd3);

      // Asynchronous reset at sample 5 of a load
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      send_burst(16'h5000, 5);
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h5005;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_state",   32'(bus.state),        32'(IDLE));
      chk("arst_wr_en",   32'(bus.wr_en),        32'd0);
      chk("arst_wr_addr", 32'(bus.wr_addr),      32'd0);
      chk("arst_wr_data", 32'(bus.wr_data),      32'd0);
      chk("arst_count",   32'(bus.sample_count), 32'd0);
      chk("arst_busy",    32'(bus.busy),         32'd0);
      chk("arst_done",    32'(bus.done),         32'd0);
      chk("arst_play_en", 32'(bus.play_en),      32'd0);
      chk("arst_s_ready", 32'(bus.s_ready),      32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("post_rst_wr_en", 32'(bus.wr_en), 32'd0);
         chk("post_rst_state", 32'(bus.state), 32'(IDLE));
      end
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("restart_state", 32'(bus.state),        32'(LOAD));
      chk("restart_count", 32'(bus.sample_count), 32'd0);
      step();
      bus.s_valid = 1'b0;
      chk("restart_wr_en",   32'(bus.wr_en),   32'd1);
      chk("restart_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("restart_wr_data", 32'(bus.wr_data), 32'h5005);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
